// File: rtl/pfd_charge_pump.sv
// Phase-frequency detector with a saturating digital charge pump.
// refclk/fbclk are oversampled by clk; up/down pulse widths in clk cycles
// equal the phase error, and vctrl integrates them as the loop-filter code.
module pfd_charge_pump #(
    parameter int unsigned CODE_W    = 12,
    parameter int unsigned STEP      = 16,
    parameter int unsigned INIT_CODE = 2048
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              refclk,
    input  logic              fbclk,
    output logic              up,
    output logic              down,
    output logic [CODE_W-1:0] vctrl,
    output logic              sat_hi,
    output logic              sat_lo
);

    localparam logic [CODE_W:0]   MAX_X  = {1'b0, {CODE_W{1'b1}}};
    localparam logic [CODE_W:0]   STEP_X = (CODE_W + 1)'(STEP);
    localparam logic [CODE_W-1:0] INIT_V = CODE_W'(INIT_CODE);

    // bit 0 = s1, bit 1 = s2, bit 2 = history (s3)
    logic [2:0] ref_sync;
    logic [2:0] fb_sync;

    logic ref_rise;
    logic fb_rise;
    logic up_n;
    logic dn_n;
    logic up_nxt;
    logic down_nxt;

    logic [CODE_W:0]   sum_x;
    logic [CODE_W:0]   diff_x;
    logic [CODE_W-1:0] vctrl_nxt;

    // Synchronizers keep running regardless of en so re-enabling never sees a stale edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_sync <= '0;
            fb_sync  <= '0;
        end else begin
            ref_sync <= {ref_sync[1:0], refclk};
            fb_sync  <= {fb_sync[1:0], fbclk};
        end
    end

    assign ref_rise = ref_sync[1] & ~ref_sync[2];
    assign fb_rise  = fb_sync[1] & ~fb_sync[2];

    // PFD next state: clearing both at once when both would be set gives zero dead zone
    always_comb begin
        up_nxt   = 1'b0;
        down_nxt = 1'b0;
        up_n     = up | ref_rise;
        dn_n     = down | fb_rise;
        if (en && !(up_n && dn_n)) begin
            up_nxt   = up_n;
            down_nxt = dn_n;
        end
    end

    // PFD state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            up   <= 1'b0;
            down <= 1'b0;
        end else begin
            up   <= up_nxt;
            down <= down_nxt;
        end
    end

    // Charge pump: one extra bit catches overflow/borrow so the code clamps instead of wrapping
    always_comb begin
        sum_x     = {1'b0, vctrl} + STEP_X;
        diff_x    = {1'b0, vctrl} - STEP_X;
        vctrl_nxt = vctrl;
        if (up && !down) begin
            vctrl_nxt = (sum_x > MAX_X) ? MAX_X[CODE_W-1:0] : sum_x[CODE_W-1:0];
        end else if (down && !up) begin
            vctrl_nxt = diff_x[CODE_W] ? '0 : diff_x[CODE_W-1:0];
        end
    end

    // Loop-filter code register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vctrl <= INIT_V;
        end else begin
            vctrl <= vctrl_nxt;
        end
    end

    assign sat_hi = (vctrl == {CODE_W{1'b1}});
    assign sat_lo = (vctrl == '0);

endmodule

// File: tb/tb_pfd_charge_pump.sv
// Directed bench for pfd_charge_pump: expected output words are queued as
// stimulus is planned and popped one per clk cycle as the DUT responds.
module tb_pfd_charge_pump;

    logic        clk;
    logic        rst;
    logic        en;
    logic        refclk;
    logic        fbclk;
    logic        up;
    logic        down;
    logic [11:0] vctrl;
    logic        sat_hi;
    logic        sat_lo;

    int errors = 0;
    int checks = 0;

    logic [15:0] exp_q[$];
    string       tag_q[$];

    pfd_charge_pump dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .refclk (refclk),
        .fbclk  (fbclk),
        .up     (up),
        .down   (down),
        .vctrl  (vctrl),
        .sat_hi (sat_hi),
        .sat_lo (sat_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output word layout: {up, down, sat_hi, sat_lo, vctrl}
    function automatic logic [15:0] pack(input logic u, input logic d, input int v);
        logic [11:0] c;
        c = 12'(v);
        return {u, d, (c == 12'hFFF), (c == 12'h000), c};
    endfunction

    task automatic push(input string t, input logic u, input logic d, input int v);
        exp_q.push_back(pack(u, d, v));
        tag_q.push_back(t);
    endtask

    task automatic check_next();
        logic [15:0] obs;
        logic [15:0] e;
        string       t;
        obs = {up, down, sat_hi, sat_lo, vctrl};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed=%h expected=<none>", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed {up,dn,hi,lo,code}=%h expected=%h", t, obs, e);
            end
        end
    endtask

    task automatic push_check(input string t, input logic u, input logic d, input int v);
        push(t, u, d, v);
        check_next();
    endtask

    // Drop both inputs and let the synchronizers settle
    task automatic settle(input int n);
        @(negedge clk);
        refclk = 1'b0;
        fbclk  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Reset with toggling inputs; checks immediate effect, hold, and release before first edge
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1 push_check("rst_async", 1'b0, 1'b0, 2048);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            push_check($sformatf("rst_hold[%0d]", i), 1'b0, 1'b0, 2048);
            refclk = ~refclk;
            fbclk  = (i % 2 == 0);
        end
        @(negedge clk);
        refclk = 1'b0;
        fbclk  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1 push_check("rst_release", 1'b0, 1'b0, 2048);
        en = 1'b1;
    endtask

    // Rising edges at iterations t_ref/t_fb; sample m follows the m-th edge after the first drive.
    // Leading edge at t0 gives a pulse seen at samples t0+3..t0+N+2 and N code steps.
    task automatic run_pair(input string t, input int t_ref, input int t_fb, input int ncyc, input int v0);
        int lead, t0, n, steps, v;
        logic u, d;
        lead = t_fb - t_ref;
        t0   = (t_ref < t_fb) ? t_ref : t_fb;
        n    = (lead < 0) ? -lead : lead;
        for (int m = 1; m <= ncyc; m++) begin
            u = (lead > 0) && (m >= t0 + 3) && (m <= t0 + n + 2);
            d = (lead < 0) && (m >= t0 + 3) && (m <= t0 + n + 2);
            steps = m - t0 - 3;
            if (steps < 0) steps = 0;
            if (steps > n) steps = n;
            v = v0 + ((lead > 0) ? 16 : -16) * steps;
            push($sformatf("%s[%0d]", t, m), u, d, v);
        end
        for (int i = 0; i <= ncyc; i++) begin
            @(negedge clk);
            if (i > 0) check_next();
            if (i == t_ref) refclk = 1'b1;
            if (i == t_fb)  fbclk  = 1'b1;
        end
        settle(4);
    endtask

    // One input toggles (4 high/4 low), the other held low; code must ramp and clamp
    task automatic sat_run(input string t, input bit dir_up, input int ncyc);
        int steps, v;
        for (int m = 1; m <= ncyc; m++) begin
            steps = (m >= 3) ? m - 3 : 0;
            if (dir_up) begin
                v = 2048 + 16 * steps;
                if (v > 4095) v = 4095;
            end else begin
                v = 2048 - 16 * steps;
                if (v < 0) v = 0;
            end
            push($sformatf("%s[%0d]", t, m), dir_up && (m >= 3), !dir_up && (m >= 3), v);
        end
        for (int i = 0; i <= ncyc; i++) begin
            @(negedge clk);
            if (i > 0) check_next();
            if (dir_up) refclk = ((i / 4) % 2 == 0);
            else        fbclk  = ((i / 4) % 2 == 0);
        end
        settle(4);
    endtask

    initial begin
        rst    = 1'b1;
        en     = 1'b1;
        refclk = 1'b0;
        fbclk  = 1'b0;

        do_reset();

        // Reference leads by 5: up for 5 cycles, +80
        run_pair("ref_lead", 0, 5, 10, 2048);

        // Feedback leads by 3: down for 3 cycles, -48
        do_reset();
        run_pair("fb_lead", 3, 0, 9, 2048);

        // Coincident rises never produce a pulse
        do_reset();
        for (int r = 0; r < 10; r++) begin
            run_pair($sformatf("coinc%0d", r), 0, 0, 5, 2048);
        end

        // Frequency detection and clamping at both rails
        do_reset();
        sat_run("sat_hi", 1'b1, 150);
        do_reset();
        sat_run("sat_lo", 1'b0, 150);

        // en dropped while up is high: last step still taken on that edge, then frozen
        do_reset();
        for (int m = 1; m <= 12; m++) begin
            int s;
            s = m - 3;
            if (s < 0) s = 0;
            if (s > 3) s = 3;
            push($sformatf("en_off[%0d]", m), (m >= 3) && (m <= 5), 1'b0, 2048 + 16 * s);
        end
        for (int i = 0; i <= 12; i++) begin
            @(negedge clk);
            if (i > 0) check_next();
            if (i == 0) refclk = 1'b1;
            if (i == 5) en = 1'b0;
            if (i == 8) en = 1'b1;
        end
        settle(4);

        // Reset asserted mid-pulse returns outputs at once
        do_reset();
        for (int m = 1; m <= 6; m++) begin
            int s;
            s = (m >= 3) ? m - 3 : 0;
            push($sformatf("mid_pulse[%0d]", m), m >= 3, 1'b0, 2048 + 16 * s);
        end
        for (int i = 0; i <= 6; i++) begin
            @(negedge clk);
            if (i > 0) check_next();
            if (i == 0) refclk = 1'b1;
        end
        rst = 1'b1;
        #1 push_check("mid_rst_async", 1'b0, 1'b0, 2048);
        @(negedge clk);
        refclk = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            push_check($sformatf("mid_rst_after[%0d]", i), 1'b0, 1'b0, 2048);
        end

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_leftover: observed=%0d entries expected=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pfd_charge_pump.md
# pfd_charge_pump

Synchronous, single-clock model of the PLL front end: a phase-frequency detector followed by a digital charge pump. The block oversamples the reference clock and the divided feedback clock with a fast system clock. It produces UP/DOWN pulses whose width in clk cycles equals the phase error between the two clocks. It integrates those pulses into a saturating control code, the digital equivalent of the 0–3.0 V loop-filter node, which drives the downstream oscillator model.

## Interface
- CODE_W, 12: width of control code `vctrl`.
- STEP, 16: code change per clk cycle while `up` or `down` is asserted (charge-pump current).
- INIT_CODE, 2048: reset value of `vctrl` (mid-rail, 1.5 V of 3.0 V).
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- en  input  1  detector enable (PFD D input); 0 forces `up`/`down` low.
- refclk  input  1  reference clock, asynchronous to clk.
- fbclk  input  1  feedback (divided VCO) clock, asynchronous to clk.
- up  output  1  PFD UP pulse (feedback lags reference).
- down  output  1  PFD DOWN pulse (feedback leads reference).
- vctrl  output  CODE_W  integrated control code, unsigned.
- sat_hi  output  1  `vctrl` equals 2^CODE_W−1.
- sat_lo  output  1  `vctrl` equals 0.

## Operation
- Input capture: `refclk` and `fbclk` each pass through a 2-flop synchronizer (s1, s2) plus a history flop s3.
  - ref_rise = r_s2 & ~r_s3.
  - fb_rise = f_s2 & ~f_s3.
- PFD state: up_n = up | ref_rise and dn_n = down | fb_rise.
  - If up_n & dn_n, both `up` and `down` are cleared. This is zero-dead-zone reset: no overlap cycle.
  - Otherwise `up` <= up_n and `down` <= dn_n.
- Consequences:
  - Coincident rises in the same cycle produce no pulse.
  - A pending `up` is cleared by the next fb_rise.
  - A pending `down` is cleared by the next ref_rise.
  - Repeated ref_rise with no fb_rise keeps `up` high indefinitely (frequency detection). The mirror case holds for `down`.
- en = 0: `up`/`down` are synchronously cleared and held 0, and edges are ignored. Synchronizers keep running, so no false edge occurs when en returns to 1.
- Charge pump, evaluated each cycle from the registered `up`/`down`:
  - up & ~down: vctrl <= min(vctrl+STEP, 2^CODE_W−1).
  - down & ~up: vctrl <= max(vctrl−STEP, 0).
  - Otherwise `vctrl` holds.
  - Arithmetic is done in CODE_W+1 bits, then clamped. Wrap-around is never permitted.
- `sat_hi` and `sat_lo` are combinational decodes of `vctrl`.

## Timing
- Reset values (asserted asynchronously, immediately):
  - All synchronizer/history flops 0.
  - up=0, down=0.
  - vctrl=INIT_CODE, sat_hi=0, sat_lo=0.
- Release is sampled on clk; the first update occurs on the first clk edge with rst=0.
- Latency: an input rise setting up before clk edge k is captured in s1 at k and s2 at k+1.
  - `up`/`down` asserts after edge k+2.
  - The first `vctrl` step occurs at edge k+3.
- Pulse width: `up` stays high N cycles when fbclk rises N clk cycles after refclk (same sampling phase). `vctrl` then changes by N·STEP, clamped.
- Reset mid-pulse: outputs return to reset values at once, and in-flight edges are discarded.
- Input pulses shorter than one clk period may be missed. clk must be at least 4× the faster input frequency.

## Test plan
- Reset: assert rst with refclk/fbclk toggling -> up=0, down=0, vctrl=2048, sat_hi=sat_lo=0, during reset and after release until the first edge.
- Ref leads: refclk rises 5 clk cycles before fbclk -> `up` high exactly 5 cycles, rising 2 edges after capture; `down` stays 0; vctrl=2128.
- Fb leads: fbclk rises 3 cycles before refclk -> `down` high 3 cycles; vctrl=2000.
- Coincident: both rise in the same clk cycle, repeated 10 times -> up=down=0 throughout; vctrl stays 2048.
- Saturation: refclk toggling, fbclk held 0 -> `up` stays 1; vctrl reaches 4095 and clamps; sat_hi=1, with no wrap. Mirror case with refclk held 0 -> vctrl=0, sat_lo=1.
- Enable/reset mid-operation: set en=0 while `up` is high -> `up`=0 next cycle and vctrl frozen. Assert rst mid-pulse -> immediate return to vctrl=2048.
